// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image geometry, pixel type and window-stream state encodings
package img_pkg;

  localparam int IMG_DIM    = 20;
  localparam int BIT_LENGTH = 5;

  typedef logic [BIT_LENGTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } win_state_t;

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - pixel FIFO, NPIX-wide write of wr_cnt lanes, 1-wide read, depth 2*NPIX
module pix_fifo #(
  parameter  int W     = 5,
  parameter  int NPIX  = 3,
  localparam int DEPTH = 2 * NPIX,
  localparam int CNTW  = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = $clog2(2 * DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CNTW-1:0]   wr_cnt,
  input  logic [NPIX*W-1:0] wr_data,
  input  logic              rd_en,
  output logic [W-1:0]      rd_data,
  output logic [CNTW-1:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Depth is not a power of two, so pointer sums are folded back by one subtraction.
  function automatic logic [AW-1:0] wrap(input logic [PW-1:0] v);
    logic [PW-1:0] t;
    t = (v >= PW'(DEPTH)) ? v - PW'(DEPTH) : v;
    return t[AW-1:0];
  endfunction

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        for (int i = 0; i < NPIX; i++)
          if (CNTW'(i) < wr_cnt) mem[wrap(PW'(wr_ptr) + PW'(i))] <= wr_data[i*W +: W];
        wr_ptr <= wrap(PW'(wr_ptr) + PW'(wr_cnt));
      end
      if (rd_en) rd_ptr <= wrap(PW'(rd_ptr) + PW'(1));
      count <= count + (wr_en ? wr_cnt : '0) - CNTW'(rd_en);
    end
  end

endmodule

// File: rtl/img_window_stream.sv
// rtl/img_window_stream.sv - raster pixel stream in, every fully-inside KSIZE x KSIZE window out
module img_window_stream #(
  parameter  int IMG_DIM    = img_pkg::IMG_DIM,
  parameter  int BIT_LENGTH = img_pkg::BIT_LENGTH,
  parameter  int NPIX       = 3,
  parameter  int KSIZE      = 3,
  localparam int CW         = $clog2(IMG_DIM)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NPIX*BIT_LENGTH-1:0]        pixel_in,
  output logic                              win_valid,
  input  logic                              win_ready,
  output logic [KSIZE*KSIZE*BIT_LENGTH-1:0] win_data,
  output logic [CW-1:0]                     win_row,
  output logic [CW-1:0]                     win_col,
  output logic                              win_last,
  output logic                              frame_done
);
  import img_pkg::*;

  localparam int B     = BIT_LENGTH;
  localparam int TOTAL = IMG_DIM * IMG_DIM;
  localparam int TW    = $clog2(TOTAL + 1);
  localparam int CNTW  = $clog2(2 * NPIX + 1);
  localparam int H     = (KSIZE - 1) / 2;

  win_state_t    state, state_next;
  logic [TW-1:0] in_cnt, remaining;
  logic [CNTW-1:0] wr_cnt, fifo_count;
  logic [B-1:0]  fifo_data;
  logic          accept, last_beat, out_free, consume, emit_now, fire_last;
  logic [CW-1:0] r, c;
  logic [B-1:0]  lb  [KSIZE-1][IMG_DIM];
  logic [B-1:0]  sr  [KSIZE][KSIZE];
  logic [B-1:0]  col [KSIZE];
  logic          emit_p, em_last;
  logic [CW-1:0] em_row, em_col;

  assign in_ready   = (state == LOAD) && (fifo_count <= CNTW'(NPIX));
  assign accept     = in_valid && in_ready;
  assign remaining  = TW'(TOTAL) - in_cnt;
  assign wr_cnt     = (remaining < TW'(NPIX)) ? CNTW'(remaining) : CNTW'(NPIX);
  assign last_beat  = accept && (remaining <= TW'(NPIX));
  assign out_free   = !win_valid || win_ready;
  assign consume    = (fifo_count != '0) && out_free;
  assign emit_now   = consume && (r >= CW'(KSIZE - 1)) && (c >= CW'(KSIZE - 1));
  assign fire_last  = win_valid && win_ready && win_last;
  assign frame_done = (state == DONE);

  pix_fifo #(.W(B), .NPIX(NPIX)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_cnt  (wr_cnt),
    .wr_data (pixel_in),
    .rd_en   (consume),
    .rd_data (fifo_data),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = LOAD;
      LOAD:    if (last_beat) state_next = DRAIN;
      DRAIN:   if (fire_last && fifo_count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               in_cnt <= '0;
    else if (state == IDLE)  in_cnt <= '0;
    else if (accept)         in_cnt <= in_cnt + TW'(wr_cnt);
  end

  // New column entering the window: older rows from the line buffers, newest pixel at the bottom.
  always_comb begin
    for (int i = 0; i < KSIZE - 1; i++) col[i] = lb[i][c];
    col[KSIZE-1] = fifo_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r <= '0;
      c <= '0;
      for (int i = 0; i < KSIZE - 1; i++)
        for (int j = 0; j < IMG_DIM; j++) lb[i][j] <= '0;
      for (int i = 0; i < KSIZE; i++)
        for (int j = 0; j < KSIZE; j++) sr[i][j] <= '0;
    end else if (consume) begin
      for (int i = 0; i < KSIZE - 2; i++) lb[i][c] <= lb[i+1][c];
      lb[KSIZE-2][c] <= fifo_data;
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE - 1; j++) sr[i][j] <= sr[i][j+1];
        sr[i][KSIZE-1] <= col[i];
      end
      if (c == CW'(IMG_DIM - 1)) begin
        c <= '0;
        r <= (r == CW'(IMG_DIM - 1)) ? '0 : r + CW'(1);
      end else begin
        c <= c + CW'(1);
      end
    end
  end

  // One pending-window stage: sr already holds the window while emit_p waits for the output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      emit_p  <= 1'b0;
      em_row  <= '0;
      em_col  <= '0;
      em_last <= 1'b0;
    end else if (out_free) begin
      emit_p <= emit_now;
      if (emit_now) begin
        em_row  <= r - CW'(H);
        em_col  <= c - CW'(H);
        em_last <= (r == CW'(IMG_DIM - 1)) && (c == CW'(IMG_DIM - 1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
      win_last  <= 1'b0;
    end else if (out_free) begin
      win_valid <= emit_p;
      win_last  <= emit_p && em_last;
      if (emit_p) begin
        win_row <= em_row;
        win_col <= em_col;
        for (int i = 0; i < KSIZE; i++)
          for (int j = 0; j < KSIZE; j++) win_data[(i*KSIZE+j)*B +: B] <= sr[i][j];
      end
    end
  end

endmodule
